// File: rtl/apb_spi_pkg.sv
// Shared definitions for the APB-to-SPI bridge: register offsets,
// sequencer state encoding and STATUS register bit positions.
package apb_spi_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_TXDATA = 8'h04;
  localparam logic [7:0] REG_RXDATA = 8'h08;
  localparam logic [7:0] REG_STATUS = 8'h0C;
  localparam logic [7:0] REG_IEN    = 8'h10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_SEND,
    ST_WAIT,
    ST_READ
  } seq_state_t;

  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_TX_EMPTY = 1;
  localparam int STAT_RX_FULL  = 2;
  localparam int STAT_RX_EMPTY = 3;
  localparam int STAT_BUSY     = 4;
  localparam int STAT_TX_COUNT = 8;
  localparam int STAT_RX_COUNT = 12;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head; push on full and pop on
// empty are ignored, judged on the state before the current edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers rely on DEPTH being a power of two for natural wrap-around.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/apb_spi_bridge.sv
// APB3 slave fronting spi_if: register file, TX/RX byte FIFOs and the
// sequencer that issues command and data strobes to the SPI master.
module apb_spi_bridge
  import apb_spi_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_paddr,
  input  logic              i_psel,
  input  logic              i_penable,
  input  logic              i_pwrite,
  input  logic [31:0]       i_pwdata,
  output logic [31:0]       o_prdata,
  output logic              o_pready,
  output logic              o_pslverr,
  output logic [7:0]        o_spi_din,
  output logic              o_spi_cmd,
  output logic              o_spi_wr,
  output logic              o_spi_rd,
  input  logic [7:0]        i_spi_dout,
  input  logic              i_spi_irq,
  output logic              o_irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  seq_state_t r_state;
  seq_state_t w_next_state;

  logic [7:0]        r_cmd_reg;
  logic              r_cmd_pend;
  logic [1:0]        r_ien;
  logic [7:0]        r_last_din;

  logic              w_access;
  logic              w_wr;
  logic              w_rd;
  logic [ADDR_W-1:0] w_addr;
  logic              w_is_ctrl;
  logic              w_is_tx;
  logic              w_is_rx;
  logic              w_is_status;
  logic              w_is_ien;

  logic              w_tx_push;
  logic              w_tx_pop;
  logic [7:0]        w_tx_head;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic [CNT_W-1:0]  w_tx_count;
  logic              w_rx_push;
  logic              w_rx_pop;
  logic [7:0]        w_rx_head;
  logic              w_rx_full;
  logic              w_rx_empty;
  logic [CNT_W-1:0]  w_rx_count;
  logic [3:0]        w_tx_cnt4;
  logic [3:0]        w_rx_cnt4;
  logic [31:0]       w_status;
  logic              w_busy;
  logic              w_unused;

  assign w_access    = i_psel & i_penable;
  assign w_wr        = w_access & i_pwrite;
  assign w_rd        = w_access & ~i_pwrite;
  assign w_addr      = {i_paddr[ADDR_W-1:2], 2'b00};
  assign w_is_ctrl   = (w_addr == ADDR_W'(REG_CTRL));
  assign w_is_tx     = (w_addr == ADDR_W'(REG_TXDATA));
  assign w_is_rx     = (w_addr == ADDR_W'(REG_RXDATA));
  assign w_is_status = (w_addr == ADDR_W'(REG_STATUS));
  assign w_is_ien    = (w_addr == ADDR_W'(REG_IEN));
  assign w_unused    = ^{i_pwdata[31:8], i_paddr[1:0]};

  assign w_tx_push = w_wr & w_is_tx;
  assign w_rx_pop  = w_rd & w_is_rx;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_tx_push),
    .i_pop   (w_tx_pop),
    .i_wdata (i_pwdata[7:0]),
    .o_rdata (w_tx_head),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (w_tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_rx_push),
    .i_pop   (w_rx_pop),
    .i_wdata (i_spi_dout),
    .o_rdata (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (w_rx_count)
  );

  // A CTRL write landing in the CMD cycle re-arms cmd_pend for the new value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd_reg  <= '0;
      r_cmd_pend <= 1'b0;
      r_ien      <= '0;
      r_last_din <= '0;
    end else begin
      if (w_wr && w_is_ctrl) begin
        r_cmd_reg  <= i_pwdata[7:0];
        r_cmd_pend <= 1'b1;
      end else if (r_state == ST_CMD) begin
        r_cmd_pend <= 1'b0;
      end
      if (w_wr && w_is_ien) begin
        r_ien <= i_pwdata[1:0];
      end
      if (r_state == ST_CMD) begin
        r_last_din <= r_cmd_reg;
      end else if (r_state == ST_SEND) begin
        r_last_din <= w_tx_head;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_spi_cmd    = 1'b0;
    o_spi_wr     = 1'b0;
    o_spi_rd     = 1'b0;
    o_spi_din    = r_last_din;
    w_tx_pop     = 1'b0;
    w_rx_push    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_cmd_pend) begin
          w_next_state = ST_CMD;
        end else if (!w_tx_empty && !w_rx_full) begin
          w_next_state = ST_SEND;
        end
      end
      ST_CMD: begin
        o_spi_cmd    = 1'b1;
        o_spi_din    = r_cmd_reg;
        w_next_state = ST_IDLE;
      end
      ST_SEND: begin
        o_spi_wr     = 1'b1;
        o_spi_din    = w_tx_head;
        w_tx_pop     = 1'b1;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_spi_irq) begin
          w_next_state = ST_READ;
        end
      end
      ST_READ: begin
        o_spi_rd     = 1'b1;
        w_rx_push    = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_busy    = (r_state != ST_IDLE) | r_cmd_pend;
  assign w_tx_cnt4 = 4'(w_tx_count);
  assign w_rx_cnt4 = 4'(w_rx_count);

  always_comb begin
    w_status                      = '0;
    w_status[STAT_TX_FULL]        = w_tx_full;
    w_status[STAT_TX_EMPTY]       = w_tx_empty;
    w_status[STAT_RX_FULL]        = w_rx_full;
    w_status[STAT_RX_EMPTY]       = w_rx_empty;
    w_status[STAT_BUSY]           = w_busy;
    w_status[STAT_TX_COUNT +: 3]  = w_tx_cnt4[2:0];
    w_status[STAT_RX_COUNT +: 3]  = w_rx_cnt4[2:0];
  end

  always_comb begin
    o_prdata = '0;
    if (w_rd) begin
      if (w_is_ctrl) begin
        o_prdata[7:0] = r_cmd_reg;
      end else if (w_is_rx && !w_rx_empty) begin
        o_prdata[7:0] = w_rx_head;
      end else if (w_is_status) begin
        o_prdata = w_status;
      end else if (w_is_ien) begin
        o_prdata[1:0] = r_ien;
      end
    end
  end

  assign o_pready  = 1'b1;
  assign o_pslverr = (w_wr & w_is_tx & w_tx_full) | (w_rd & w_is_rx & w_rx_empty);
  assign o_irq     = (r_ien[0] & ~w_rx_empty) |
                     (r_ien[1] & w_tx_empty & (r_state == ST_IDLE) & ~r_cmd_pend);

endmodule

// File: tb/tb_apb_spi_bridge.sv
// Scoreboard bench for apb_spi_bridge with a behavioural spi_if that
// answers each spi_wr with dout = din ^ 0xC5 after a programmable delay.
module tb_apb_spi_bridge;
  import apb_spi_pkg::*;

  localparam int ADDR_W = 5;
  localparam logic [1:0] K_CMD = 2'd1;
  localparam logic [1:0] K_WR  = 2'd2;
  localparam logic [1:0] K_RD  = 2'd3;

  typedef struct packed {
    logic        isRead;
    logic [31:0] data;
    logic        err;
  } apbExp_t;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] din;
  } spiExp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;
  logic [7:0]        spiDin;
  logic              spiCmd;
  logic              spiWr;
  logic              spiRd;
  logic [7:0]        spiDout;
  logic              spiIrq;
  logic              irq;

  apbExp_t apbQ[$];
  spiExp_t spiQ[$];
  int      checks = 0;
  int      errors = 0;

  int         irqDelay = 40;
  bit         holdIrq  = 1'b0;
  bit         pending  = 1'b0;
  int         cnt      = 0;
  logic [7:0] captured = '0;

  always #5 clk = ~clk;

  apb_spi_bridge #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_paddr   (paddr),
    .i_psel    (psel),
    .i_penable (penable),
    .i_pwrite  (pwrite),
    .i_pwdata  (pwdata),
    .o_prdata  (prdata),
    .o_pready  (pready),
    .o_pslverr (pslverr),
    .o_spi_din (spiDin),
    .o_spi_cmd (spiCmd),
    .o_spi_wr  (spiWr),
    .o_spi_rd  (spiRd),
    .i_spi_dout(spiDout),
    .i_spi_irq (spiIrq),
    .o_irq     (irq)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expectSpi(input logic [1:0] kind, input logic [7:0] din);
    spiExp_t e;
    e.kind = kind;
    e.din  = din;
    spiQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input bit write,
                               input logic [31:0] wdata, input logic [31:0] expData,
                               input bit expErr);
    apbExp_t e;
    e.isRead = !write;
    e.data   = expData;
    e.err    = expErr;
    apbQ.push_back(e);
    @(posedge clk);
    #1;
    psel    = 1'b1;
    penable = 1'b0;
    paddr   = addr;
    pwrite  = write;
    pwdata  = wdata;
    @(posedge clk);
    #1;
    penable = 1'b1;
    @(posedge clk);
    #1;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  task automatic waitForRd(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (spiRd) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("rd_timeout", 32'd0, 32'd1);
  endtask

  // Behavioural spi_if: completes a byte irqDelay cycles after spi_wr.
  initial begin
    spiIrq  = 1'b0;
    spiDout = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        spiIrq  = 1'b0;
        pending = 1'b0;
      end else begin
        if (spiRd) spiIrq = 1'b0;
        if (spiWr) begin
          pending  = 1'b1;
          captured = spiDin;
          cnt      = irqDelay;
        end else if (pending && !holdIrq) begin
          if (cnt <= 1) begin
            spiIrq  = 1'b1;
            spiDout = captured ^ 8'hC5;
            pending = 1'b0;
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // Monitor: compares every strobe and every APB access against the queues.
  initial begin
    logic [1:0] obsKind;
    int         nStrobe;
    spiExp_t    se;
    apbExp_t    ae;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        nStrobe = int'(spiCmd) + int'(spiWr) + int'(spiRd);
        obsKind = spiCmd ? K_CMD : (spiWr ? K_WR : (spiRd ? K_RD : 2'd0));
        if (nStrobe > 1) begin
          checkOutput("strobe_exclusive", nStrobe, 32'd1);
        end else if (nStrobe == 1) begin
          if (spiQ.size() == 0) begin
            checkOutput("spi_unexpected", {30'd0, obsKind}, 32'd0);
          end else begin
            se = spiQ.pop_front();
            checkOutput("spi_kind", {30'd0, obsKind}, {30'd0, se.kind});
            if (se.kind != K_RD) checkOutput("spi_din", {24'd0, spiDin}, {24'd0, se.din});
          end
        end
        if (psel && penable) begin
          if (apbQ.size() == 0) begin
            checkOutput("apb_unexpected", 32'd1, 32'd0);
          end else begin
            ae = apbQ.pop_front();
            if (ae.isRead) checkOutput("prdata", prdata, ae.data);
            checkOutput("pslverr", {31'd0, pslverr}, {31'd0, ae.err});
            checkOutput("pready", {31'd0, pready}, 32'd1);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_strobes", {29'd0, spiCmd, spiWr, spiRd}, 32'd0);
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
    checkOutput("rst_pready", {31'd0, pready}, 32'd1);
    checkOutput("rst_pslverr", {31'd0, pslverr}, 32'd0);
    checkOutput("rst_prdata", prdata, 32'd0);
    checkOutput("rst_spi_din", {24'd0, spiDin}, 32'd0);
    rst_n = 1'b1;
    applyStimulus(REG_STATUS[ADDR_W-1:0], 1'b0, 0, 32'h0000_000A, 1'b0);

    $display("[TB] CTRL command");
    expectSpi(K_CMD, 8'h37);
    applyStimulus(REG_CTRL[ADDR_W-1:0], 1'b1, 32'h37, 0, 1'b0);
    repeat (5) @(posedge clk);
    applyStimulus(REG_STATUS[ADDR_W-1:0], 1'b0, 0, 32'h0000_000A, 1'b0);
    applyStimulus(REG_CTRL[ADDR_W-1:0], 1'b0, 0, 32'h37, 1'b0);

    $display("[TB] single data byte");
    irqDelay = 40;
    expectSpi(K_WR, 8'h60);
    expectSpi(K_RD, 8'h00);
    applyStimulus(REG_TXDATA[ADDR_W-1:0], 1'b1, 32'h60, 0, 1'b0);
    repeat (60) @(posedge clk);
    applyStimulus(REG_RXDATA[ADDR_W-1:0], 1'b0, 0, 32'hA5, 1'b0);
    applyStimulus(REG_STATUS[ADDR_W-1:0], 1'b0, 0, 32'h0000_000A, 1'b0);
    applyStimulus(REG_RXDATA[ADDR_W-1:0], 1'b0, 0, 32'h0, 1'b1);

    $display("[TB] TX overflow and RX full stall");
    holdIrq  = 1'b1;
    irqDelay = 3;
    expectSpi(K_WR, 8'h01);
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(REG_TXDATA[ADDR_W-1:0], 1'b1, 32'(i), 0, i == 6);
    end
    repeat (10) @(posedge clk);
    applyStimulus(REG_STATUS[ADDR_W-1:0], 1'b0, 0, 32'h0000_0419, 1'b0);
    expectSpi(K_RD, 8'h00);
    for (int i = 2; i <= 4; i++) begin
      expectSpi(K_WR, 8'(i));
      expectSpi(K_RD, 8'h00);
    end
    holdIrq = 1'b0;
    repeat (100) @(posedge clk);
    applyStimulus(REG_STATUS[ADDR_W-1:0], 1'b0, 0, 32'h0000_4104, 1'b0);
    checkOutput("spiq_drained_at_stall", spiQ.size(), 32'd0);
    expectSpi(K_WR, 8'h05);
    expectSpi(K_RD, 8'h00);
    applyStimulus(REG_RXDATA[ADDR_W-1:0], 1'b0, 0, 32'hC4, 1'b0);
    repeat (30) @(posedge clk);
    applyStimulus(REG_RXDATA[ADDR_W-1:0], 1'b0, 0, 32'hC7, 1'b0);
    applyStimulus(REG_RXDATA[ADDR_W-1:0], 1'b0, 0, 32'hC6, 1'b0);
    applyStimulus(REG_RXDATA[ADDR_W-1:0], 1'b0, 0, 32'hC1, 1'b0);
    applyStimulus(REG_RXDATA[ADDR_W-1:0], 1'b0, 0, 32'hC0, 1'b0);
    applyStimulus(REG_STATUS[ADDR_W-1:0], 1'b0, 0, 32'h0000_000A, 1'b0);

    $display("[TB] command priority and irq");
    irqDelay = 20;
    applyStimulus(REG_IEN[ADDR_W-1:0], 1'b1, 32'h1, 0, 1'b0);
    expectSpi(K_WR, 8'h11);
    expectSpi(K_RD, 8'h00);
    expectSpi(K_CMD, 8'h02);
    applyStimulus(REG_TXDATA[ADDR_W-1:0], 1'b1, 32'h11, 0, 1'b0);
    repeat (3) @(posedge clk);
    applyStimulus(REG_STATUS[ADDR_W-1:0], 1'b0, 0, 32'h0000_001A, 1'b0);
    applyStimulus(REG_CTRL[ADDR_W-1:0], 1'b1, 32'h02, 0, 1'b0);
    checkOutput("irq_before_rx", {31'd0, irq}, 32'd0);
    waitForRd(100);
    checkOutput("irq_in_read", {31'd0, irq}, 32'd0);
    @(negedge clk);
    checkOutput("irq_after_push", {31'd0, irq}, 32'd1);
    repeat (5) @(posedge clk);
    applyStimulus(REG_RXDATA[ADDR_W-1:0], 1'b0, 0, 32'hD4, 1'b0);
    @(negedge clk);
    checkOutput("irq_after_pop", {31'd0, irq}, 32'd0);

    $display("[TB] tx_empty irq and unmapped offset");
    applyStimulus(REG_IEN[ADDR_W-1:0], 1'b1, 32'h2, 0, 1'b0);
    @(negedge clk);
    checkOutput("irq_tx_empty", {31'd0, irq}, 32'd1);
    applyStimulus(REG_IEN[ADDR_W-1:0], 1'b0, 0, 32'h2, 1'b0);
    applyStimulus(5'h14, 1'b1, 32'hFF, 0, 1'b0);
    applyStimulus(5'h14, 1'b0, 0, 32'h0, 1'b0);

    repeat (10) @(posedge clk);
    checkOutput("apbq_empty", apbQ.size(), 32'd0);
    checkOutput("spiq_empty", spiQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_spi_bridge.md
Name: apb_spi_bridge

Overview:
- APB3 slave that sits directly upstream of spi_if and gives the SoC bus access to the SPI master.
- A sequencer FSM drives spi_if's din/cmd/wr/rd strobes.
- TX bytes are buffered in a small FIFO and drained one at a time. Each received byte (spi_if dout) is captured into an RX FIFO.
- Produces one level-sensitive interrupt to the system interrupt controller.

Parameters:
- ADDR_W, 5, APB address width (byte address; bits [1:0] ignored)
- FIFO_DEPTH, 4, entries in each of TX and RX FIFO; power of two, >=2

Ports:
- clk  in  1  system clock; spi_if shares this clock
- rst  in  1  asynchronous, active-low reset
- paddr  in  ADDR_W  APB address
- psel  in  1  APB select
- penable  in  1  APB access phase
- pwrite  in  1  APB write
- pwdata  in  32  APB write data
- prdata  out  32  APB read data
- pready  out  1  always 1 (zero wait states)
- pslverr  out  1  error response
- spi_din  out  8  to spi_if din
- spi_cmd  out  1  to spi_if cmd (1-cycle strobe)
- spi_wr  out  1  to spi_if wr (1-cycle strobe)
- spi_rd  out  1  to spi_if rd (1-cycle strobe)
- spi_dout  in  8  from spi_if dout; valid while spi_irq=1
- spi_irq  in  1  from spi_if irq; 1 = byte transfer done; cleared by spi_rd
- irq  out  1  system interrupt, level

Behaviour:
- Reset (rst=0, async):
  - FIFOs empty; cmd_pend=0; CMD_REG=0x00; IEN=0; FSM=IDLE.
  - All outputs 0 except pready=1.
- APB access:
  - Registers sample on psel&penable; prdata is combinational during the access phase and 0 otherwise.
  - pslverr is asserted only in the access phase, for the cases listed in the register map.
- Register map (word offsets):
  - 0x00 CTRL RW [7:0]: SPI command byte (chip-select/mode per spi_if). A write sets cmd_pend=1.
  - 0x04 TXDATA WO [7:0]: push to TX FIFO. Writing when full gives pslverr=1 and the data is dropped.
  - 0x08 RXDATA RO [7:0]: pop from RX FIFO. Reading when empty gives prdata=0, pslverr=1, no pop.
  - 0x0C STATUS RO:
    - [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] busy (FSM!=IDLE or cmd_pend)
    - [8+:3] tx_count, [12+:3] rx_count
  - 0x10 IEN RW [1:0]: bit0 rx_not_empty, bit1 tx_empty.
  - Any other offset: reads 0, writes ignored, pslverr=0.
- irq = (IEN[0] & !rx_empty) | (IEN[1] & tx_empty & FSM==IDLE & !cmd_pend).
- Sequencer FSM states IDLE, CMD, SEND, WAIT, READ:
  - IDLE: cmd_pend -> CMD (priority over data). Else if !tx_empty & !rx_full -> SEND. Else stay.
  - CMD (1 cycle): spi_cmd=1, spi_din=CMD_REG, cmd_pend cleared -> IDLE.
  - SEND (1 cycle): spi_wr=1, spi_din=TX head, TX pop -> WAIT.
  - WAIT: hold until spi_irq=1 -> READ. No timeout.
  - READ (1 cycle): spi_rd=1, spi_dout pushed into RX (never full, guaranteed by the IDLE check) -> IDLE.
  - spi_din holds its last driven value outside CMD/SEND.
- Latency: TXDATA write to spi_wr is min 2 cycles (FIFO write at access edge, IDLE decision, SEND). Byte-to-byte overhead is 3 cycles plus spi_if transfer time.
- Simultaneous events:
  - Push and pop of the same FIFO in one cycle: both take effect, count unchanged; full/empty are evaluated on pre-cycle state for the push/pop guards.
  - CTRL write while FSM in SEND/WAIT/READ: the command is latched and issued after the current byte completes.
  - A second CTRL write before issue overwrites CMD_REG; only one command is sent.
- FIFO pointers wrap modulo FIFO_DEPTH; count is ptr-width+1 bits.
- Reset mid-transfer clears all state immediately. Any partially shifted byte is abandoned; spi_if is on the same reset.

Decomposition:
- Package apb_spi_pkg holds:
  - register offset constants (REG_CTRL, REG_TXDATA, REG_RXDATA, REG_STATUS, REG_IEN)
  - FSM state encoding
  - STATUS bit positions
- One sub-module, sync_fifo (params WIDTH=8, DEPTH), instantiated twice for TX and RX. It provides push/pop/full/empty/count; read data is the combinational head.

Test Plan:
- Reset: hold rst=0 then release -> STATUS reads 0x0000_000A (tx_empty, rx_empty), irq=0, all spi_* strobes 0.
- CTRL write: write CTRL=0x37 -> exactly one spi_cmd pulse with spi_din=0x37, then STATUS.busy=0.
- Data byte: write TXDATA=0x60; model spi_if raises spi_irq 40 cycles after spi_wr with spi_dout=0xA5 -> one spi_wr pulse with spi_din=0x60, one spi_rd pulse; RXDATA read returns 0xA5 then rx_empty=1.
- TX overflow: with spi_irq held 0, write TXDATA 6 times (0x01..0x06) -> the 6th write gets pslverr=1 and the sequencer eventually sends 0x01..0x05 in order.
- RX full stall: with DEPTH=4, 5 bytes sent and RX not read -> after the 4th byte the FSM stays IDLE with tx_count=1. Reading RXDATA once releases the 5th spi_wr.
- Priority and irq: queue TXDATA 0x11, write CTRL=0x02 during WAIT -> spi_cmd with 0x02 follows the 0x11 spi_rd. With IEN=0x1, irq rises the cycle after the RX push and falls after the RXDATA read empties RX.
